// File: rtl/mtimer_irq_ctrl.sv
// Machine-mode interrupt source block: 64-bit mtime/mtimecmp timer, software
// interrupt bit and synchronised external request behind a Wishbone window.
module mtimer_irq_ctrl #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_addr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    input  logic        ext_irq_i,
    output logic        int_meip_o,
    output logic        int_mtip_o,
    output logic        int_msip_o
);

    localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

    localparam logic [2:0] OFF_MSIP    = 3'd0;
    localparam logic [2:0] OFF_CMP_LO  = 3'd2;
    localparam logic [2:0] OFF_CMP_HI  = 3'd3;
    localparam logic [2:0] OFF_TIME_LO = 3'd4;
    localparam logic [2:0] OFF_TIME_HI = 3'd5;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  sel_v);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            res[i*8 +: 8] = sel_v[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
        end
        return res;
    endfunction

    logic [63:0] mtime_r;
    logic [63:0] mtimecmp_r;
    logic [15:0] presc_r;
    logic        msip_r;
    logic        mtip_r;
    logic        meip_sync1_r;
    logic        meip_sync2_r;
    logic        ack_r;
    logic        err_r;
    logic [31:0] dat_r;

    logic        req_s;
    logic        wr_s;
    logic        tick_s;
    logic        mapped_s;
    logic [2:0]  off_s;
    logic [31:0] rd_data_s;
    logic [63:0] mtime_nxt_s;
    logic [63:0] mtimecmp_nxt_s;
    logic [15:0] presc_nxt_s;
    logic        msip_nxt_s;
    logic        unused_s;

    assign off_s    = wb_addr_i[4:2];
    assign unused_s = ^wb_addr_i[1:0];
    // A pending response blocks a held strobe, giving one response every second cycle
    assign req_s    = wb_cyc_i & wb_stb_i & ~ack_r & ~err_r;
    assign wr_s     = req_s & wb_we_i;
    assign tick_s   = (presc_r == PRESC_LAST);

    // Address decode and read mux on pre-edge register values
    always_comb begin
        mapped_s  = 1'b1;
        rd_data_s = 32'h0000_0000;
        case (off_s)
            OFF_MSIP:    rd_data_s = {31'h0000_0000, msip_r};
            OFF_CMP_LO:  rd_data_s = mtimecmp_r[31:0];
            OFF_CMP_HI:  rd_data_s = mtimecmp_r[63:32];
            OFF_TIME_LO: rd_data_s = mtime_r[31:0];
            OFF_TIME_HI: rd_data_s = mtime_r[63:32];
            default:     mapped_s  = 1'b0;
        endcase
    end

    // Next state: prescaler, timer increment, and byte-masked register writes
    always_comb begin
        presc_nxt_s    = tick_s ? 16'h0000 : presc_r + 16'h0001;
        mtime_nxt_s    = tick_s ? mtime_r + 64'h1 : mtime_r;
        mtimecmp_nxt_s = mtimecmp_r;
        msip_nxt_s     = msip_r;
        if (wr_s) begin
            case (off_s)
                OFF_MSIP:    msip_nxt_s = wb_sel_i[0] ? wb_dat_i[0] : msip_r;
                OFF_CMP_LO:  mtimecmp_nxt_s[31:0]  = merge_bytes(mtimecmp_r[31:0], wb_dat_i, wb_sel_i);
                OFF_CMP_HI:  mtimecmp_nxt_s[63:32] = merge_bytes(mtimecmp_r[63:32], wb_dat_i, wb_sel_i);
                // A software write to mtime replaces this edge's increment
                OFF_TIME_LO: mtime_nxt_s = {mtime_r[63:32], merge_bytes(mtime_r[31:0], wb_dat_i, wb_sel_i)};
                OFF_TIME_HI: mtime_nxt_s = {merge_bytes(mtime_r[63:32], wb_dat_i, wb_sel_i), mtime_r[31:0]};
                default:     mtimecmp_nxt_s = mtimecmp_r;
            endcase
        end else begin
            msip_nxt_s = msip_r;
        end
    end

    // Timer, compare, software-interrupt and bus-response registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            presc_r    <= 16'h0000;
            mtime_r    <= 64'h0;
            mtimecmp_r <= 64'hFFFF_FFFF_FFFF_FFFF;
            msip_r     <= 1'b0;
            mtip_r     <= 1'b0;
            ack_r      <= 1'b0;
            err_r      <= 1'b0;
            dat_r      <= 32'h0000_0000;
        end else begin
            presc_r    <= presc_nxt_s;
            mtime_r    <= mtime_nxt_s;
            mtimecmp_r <= mtimecmp_nxt_s;
            msip_r     <= msip_nxt_s;
            mtip_r     <= (mtime_r >= mtimecmp_r);
            ack_r      <= req_s & mapped_s;
            err_r      <= req_s & ~mapped_s;
            dat_r      <= (req_s & mapped_s & ~wb_we_i) ? rd_data_s : 32'h0000_0000;
        end
    end

    // Two-flop synchroniser for the asynchronous external request
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            meip_sync1_r <= 1'b0;
            meip_sync2_r <= 1'b0;
        end else begin
            meip_sync1_r <= ext_irq_i;
            meip_sync2_r <= meip_sync1_r;
        end
    end

    assign wb_dat_o   = dat_r;
    assign wb_ack_o   = ack_r;
    assign wb_err_o   = err_r;
    assign int_meip_o = meip_sync2_r;
    assign int_mtip_o = mtip_r;
    assign int_msip_o = msip_r;

endmodule
